// File: rtl/absorb_permute_fsm_pkg.sv
// Shared types and constants for the SHAKE absorb/permute control slice.
package absorb_permute_fsm_pkg;

    localparam int KECCAK_NUM_ROUNDS = 24;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_ABSORB,
        ST_PERMUTE,
        ST_COPY,
        ST_DRAIN,
        ST_FLUSH
    } absorb_state_t;

endpackage

// File: rtl/absorb_permute_fsm_if.sv
// Control bus between the load stage, the absorb/permute sequencer, the Keccak datapath and the squeeze stage.
interface absorb_permute_fsm_if #(
    parameter int RIDX_W = 5
);
    logic              input_buffer_ready_wr;
    logic              last_block_in_buffer_wr;
    logic              input_buffer_ready;
    logic              output_size_reached;
    logic              output_buffer_ready_clr;
    logic              output_buffer_ready;
    logic              state_reset;
    logic              absorb_enable;
    logic              round_enable;
    logic [RIDX_W-1:0] round_index;
    logic              copy_enable;
    logic              busy;

    modport slave (
        input  input_buffer_ready_wr,
        input  last_block_in_buffer_wr,
        input  output_size_reached,
        input  output_buffer_ready_clr,
        output input_buffer_ready,
        output output_buffer_ready,
        output state_reset,
        output absorb_enable,
        output round_enable,
        output round_index,
        output copy_enable,
        output busy
    );

    modport master (
        output input_buffer_ready_wr,
        output last_block_in_buffer_wr,
        output output_size_reached,
        output output_buffer_ready_clr,
        input  input_buffer_ready,
        input  output_buffer_ready,
        input  state_reset,
        input  absorb_enable,
        input  round_enable,
        input  round_index,
        input  copy_enable,
        input  busy
    );

endinterface

// File: rtl/absorb_permute_fsm_handshake_flag.sv
// Set/clear handshake flag with set priority; a tag is captured whenever a set is accepted.
// A set arriving while the flag is already full is dropped unless that same cycle also clears it.
module absorb_permute_fsm_handshake_flag #(
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             flag_o,
    output logic [TAG_W-1:0] tag_o
);
    logic             flag_q, flag_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             accept;

    assign accept = set_i && (!flag_q || clr_i);

    always_comb begin
        flag_d = flag_q;
        tag_d  = tag_q;
        if (accept) begin
            flag_d = 1'b1;
            tag_d  = tag_i;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            flag_q <= flag_d;
            tag_q  <= tag_d;
        end
    end

    assign flag_o = flag_q;
    assign tag_o  = tag_q;

endmodule

// File: rtl/absorb_permute_fsm.sv
// Second-stage SHAKE control: absorbs loaded blocks, sequences Keccak-f rounds, and feeds squeeze.
// Strobes decode only the registered state and flags, so the datapath never sees input-driven glitches.
module absorb_permute_fsm #(
    parameter int NUM_ROUNDS       = absorb_permute_fsm_pkg::KECCAK_NUM_ROUNDS,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int RIDX_W           = $clog2(NUM_ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    absorb_permute_fsm_if.slave bus
);
    import absorb_permute_fsm_pkg::*;

    localparam logic [RIDX_W-1:0] LAST_CNT = RIDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [RIDX_W-1:0] STEP     = RIDX_W'(ROUNDS_PER_CYCLE);

    absorb_state_t     state_q;
    logic [RIDX_W-1:0] round_cnt_q;
    logic              last_r_q;

    logic in_rdy;
    logic last_blk;
    logic out_rdy;
    logic absorb_en;
    logic copy_en;
    logic out_tag_unused;

    absorb_permute_fsm_handshake_flag #(.TAG_W(1)) u_in_flag (
        .clk    (clk),
        .rst    (rst),
        .set_i  (bus.input_buffer_ready_wr),
        .clr_i  (absorb_en),
        .tag_i  (bus.last_block_in_buffer_wr),
        .flag_o (in_rdy),
        .tag_o  (last_blk)
    );

    absorb_permute_fsm_handshake_flag #(.TAG_W(1)) u_out_flag (
        .clk    (clk),
        .rst    (rst),
        .set_i  (copy_en),
        .clr_i  (bus.output_buffer_ready_clr),
        .tag_i  (1'b0),
        .flag_o (out_rdy),
        .tag_o  (out_tag_unused)
    );

    assign absorb_en = (state_q == ST_ABSORB);
    // Copy is held off while the squeeze stage still owns the output buffer.
    assign copy_en   = (state_q == ST_COPY) && !out_rdy;

    assign bus.input_buffer_ready  = in_rdy;
    assign bus.output_buffer_ready = out_rdy;
    assign bus.state_reset         = (state_q == ST_RESET) || (state_q == ST_FLUSH);
    assign bus.absorb_enable       = absorb_en;
    assign bus.round_enable        = (state_q == ST_PERMUTE);
    assign bus.round_index         = (state_q == ST_PERMUTE) ? round_cnt_q : '0;
    assign bus.copy_enable         = copy_en;
    assign bus.busy                = (state_q != ST_RESET) && (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            round_cnt_q <= '0;
            last_r_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (in_rdy) state_q <= ST_ABSORB;
                end
                ST_ABSORB: begin
                    last_r_q    <= last_blk;
                    round_cnt_q <= '0;
                    state_q     <= ST_PERMUTE;
                end
                ST_PERMUTE: begin
                    if (round_cnt_q == LAST_CNT) begin
                        round_cnt_q <= '0;
                        state_q     <= last_r_q ? ST_COPY : ST_IDLE;
                    end else begin
                        round_cnt_q <= round_cnt_q + STEP;
                    end
                end
                ST_COPY: begin
                    if (!out_rdy) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // last_r_q stays set so a further squeeze permutation ends in COPY again.
                    if (!out_rdy) state_q <= bus.output_size_reached ? ST_FLUSH : ST_PERMUTE;
                end
                ST_FLUSH: begin
                    last_r_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_RESET;
            endcase
        end
    end

endmodule
